// File: rtl/vrms_scan_ctrl_pkg.sv
// Shared types and derived-constant helpers for the RMS scan sequencer.
package vrms_scan_ctrl_pkg;

   // Sequencer phases for one channel visit, plus scan-level idle/done.
   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StAccum,
      StRoot,
      StStore,
      StDone
   } state_e;

   // Number of channels addressed by a CH_W-bit index.
   function automatic int unsigned n_ch(input int unsigned ch_w);
      return 1 << ch_w;
   endfunction

   // Samples per accumulation window.
   function automatic int unsigned win_len(input int unsigned bit_points);
      return 1 << bit_points;
   endfunction

   // Phase counter width: must reach the longest phase length minus one.
   function automatic int unsigned cnt_width(input int unsigned settle,
                                             input int unsigned win,
                                             input int unsigned tmo);
      int unsigned m;
      m = (settle > win) ? settle : win;
      m = (m > tmo) ? m : tmo;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/vrms_scan_ctrl_next_ch.sv
// Priority finder: lowest enabled channel strictly above cur_i, or the lowest
// enabled channel overall when from_start_i is set.
module vrms_next_ch #(
   parameter int unsigned CH_W = 2
) (
   input  logic [(1<<CH_W)-1:0] mask_i,
   input  logic [CH_W-1:0]      cur_i,
   input  logic                 from_start_i,
   output logic [CH_W-1:0]      nxt_o,
   output logic                 found_o
);

   localparam int unsigned NCh = 1 << CH_W;

   // Scan downwards so the last hit, the lowest qualifying index, wins.
   always_comb begin
      nxt_o   = '0;
      found_o = 1'b0;
      for (int i = NCh - 1; i >= 0; i--) begin
         if (mask_i[i] && (from_start_i || (i > int'(cur_i)))) begin
            nxt_o   = CH_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vrms_scan_ctrl.sv
// Channel scan sequencer for a shared square/accumulate/sqrt RMS datapath.
module vrms_scan_ctrl
   import vrms_scan_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned BIT_POINTS = 8,
   parameter int unsigned CH_W       = 2,
   parameter int unsigned SETTLE     = 4,
   parameter int unsigned ROOT_TMO   = 64
) (
   input  logic                  clk_fs,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [(1<<CH_W)-1:0]  ch_en,
   input  logic                  irq_clr,
   output logic [CH_W-1:0]       ch_sel,
   output logic                  acc_clr,
   output logic                  acc_en,
   output logic                  root_start,
   input  logic                  root_done,
   input  logic [DATA_W-2:0]     root_q,
   output logic                  rms_vld,
   output logic [CH_W-1:0]       rms_ch,
   output logic [DATA_W-2:0]     rms_val,
   input  logic [CH_W-1:0]       rd_ch,
   output logic [DATA_W-2:0]     rd_rms,
   output logic                  busy,
   output logic                  err,
   output logic                  irq
);

   localparam int unsigned NCh   = n_ch(CH_W);
   localparam int unsigned Win   = win_len(BIT_POINTS);
   localparam int unsigned CntW  = cnt_width(SETTLE, Win, ROOT_TMO);
   localparam int unsigned RmsW  = DATA_W - 1;
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
   localparam logic [CntW-1:0] WinLast    = CntW'(Win - 1);
   localparam logic [CntW-1:0] TmoLast    = CntW'(ROOT_TMO - 1);
   // With no settling time a channel visit opens directly on its window.
   localparam state_e FirstSt = (SETTLE == 0) ? StAccum : StSettle;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [NCh-1:0]    mask_q, mask_d;
   logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
   logic [RmsW-1:0]   cap_q, cap_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              irq_q, irq_d;
   logic              irq_set;
   logic              rms_vld_q, rms_vld_d;
   logic [CH_W-1:0]   rms_ch_q, rms_ch_d;
   logic [RmsW-1:0]   rms_val_q, rms_val_d;
   logic [RmsW-1:0]   res_q [NCh];
   logic [RmsW-1:0]   res_d [NCh];

   logic              from_start;
   logic [NCh-1:0]    scan_mask;
   logic [CH_W-1:0]   nxt_ch;
   logic              nxt_found;

   // Scan start (IDLE/DONE) searches the live enable mask from index -1;
   // mid-scan advances search the latched mask above the current channel.
   assign from_start = (state_q == StIdle) || (state_q == StDone);
   assign scan_mask  = from_start ? ch_en : mask_q;

   vrms_next_ch #(
      .CH_W(CH_W)
   ) u_next_ch (
      .mask_i      (scan_mask),
      .cur_i       (ch_sel_q),
      .from_start_i(from_start),
      .nxt_o       (nxt_ch),
      .found_o     (nxt_found)
   );

   // Next-state and register-update logic for the scan sequencer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      ch_sel_d  = ch_sel_q;
      cap_d     = cap_q;
      busy_d    = busy_q;
      err_d     = err_q;
      irq_set   = 1'b0;
      rms_vld_d = 1'b0;
      rms_ch_d  = rms_ch_q;
      rms_val_d = rms_val_q;
      res_d     = res_q;
      unique case (state_q)
         StIdle: begin
            if (start && (ch_en != '0)) begin
               mask_d   = ch_en;
               err_d    = 1'b0;
               ch_sel_d = nxt_ch;
               busy_d   = 1'b1;
               cnt_d    = '0;
               state_d  = FirstSt;
            end
         end
         StSettle: begin
            if (cnt_q == SettleLast) begin
               cnt_d   = '0;
               state_d = StAccum;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StAccum: begin
            if (cnt_q == WinLast) begin
               cnt_d   = '0;
               state_d = StRoot;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRoot: begin
            // A result arriving on the last allowed cycle still beats the timeout.
            if (root_done) begin
               cap_d   = root_q;
               state_d = StStore;
            end else if (cnt_q == TmoLast) begin
               cap_d   = '1;
               err_d   = 1'b1;
               state_d = StStore;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStore: begin
            res_d[ch_sel_q] = cap_q;
            rms_vld_d       = 1'b1;
            rms_ch_d        = ch_sel_q;
            rms_val_d       = cap_q;
            cnt_d           = '0;
            if (nxt_found) begin
               ch_sel_d = nxt_ch;
               state_d  = FirstSt;
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            irq_set = 1'b1;
            if (continuous && (ch_en != '0)) begin
               mask_d   = ch_en;
               ch_sel_d = nxt_ch;
               cnt_d    = '0;
               state_d  = FirstSt;
            end else begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      irq_d = irq_clr ? 1'b0 : (irq_set ? 1'b1 : irq_q);
   end

   // State, control and result-file registers.
   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         mask_q    <= '0;
         ch_sel_q  <= '0;
         cap_q     <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         irq_q     <= 1'b0;
         rms_vld_q <= 1'b0;
         rms_ch_q  <= '0;
         rms_val_q <= '0;
         res_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         ch_sel_q  <= ch_sel_d;
         cap_q     <= cap_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         irq_q     <= irq_d;
         rms_vld_q <= rms_vld_d;
         rms_ch_q  <= rms_ch_d;
         rms_val_q <= rms_val_d;
         res_q     <= res_d;
      end
   end

   assign acc_clr    = (state_q == StAccum) && (cnt_q == '0);
   assign acc_en     = (state_q == StAccum) && (cnt_q != '0);
   assign root_start = (state_q == StRoot) && (cnt_q == '0);
   assign ch_sel     = ch_sel_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign irq        = irq_q;
   assign rms_vld    = rms_vld_q;
   assign rms_ch     = rms_ch_q;
   assign rms_val    = rms_val_q;
   assign rd_rms     = res_q[rd_ch];

endmodule

// File: tb/tb_vrms_scan_ctrl.sv
// Scoreboard bench for vrms_scan_ctrl with a behavioural sqrt responder.
module tb_vrms_scan_ctrl;

   localparam int unsigned DATA_W     = 12;
   localparam int unsigned BIT_POINTS = 8;
   localparam int unsigned CH_W       = 2;
   localparam int unsigned SETTLE     = 4;
   localparam int unsigned ROOT_TMO   = 64;
   localparam int NCH  = 4;
   localparam int WIN  = 256;
   localparam int ONES = 'h7FF;

   logic        clk_fs = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic [3:0]  ch_en = '0;
   logic        irq_clr = 1'b0;
   logic        root_done = 1'b0;
   logic [10:0] root_q = '0;
   logic [1:0]  rd_ch = '0;
   logic [1:0]  ch_sel, rms_ch;
   logic        acc_clr, acc_en, root_start, rms_vld, busy, err, irq;
   logic [10:0] rms_val, rd_rms;

   vrms_scan_ctrl #(
      .DATA_W(DATA_W), .BIT_POINTS(BIT_POINTS), .CH_W(CH_W),
      .SETTLE(SETTLE), .ROOT_TMO(ROOT_TMO)
   ) dut (
      .clk_fs(clk_fs), .rst_n(rst_n), .start(start), .continuous(continuous),
      .ch_en(ch_en), .irq_clr(irq_clr), .ch_sel(ch_sel), .acc_clr(acc_clr),
      .acc_en(acc_en), .root_start(root_start), .root_done(root_done),
      .root_q(root_q), .rms_vld(rms_vld), .rms_ch(rms_ch), .rms_val(rms_val),
      .rd_ch(rd_ch), .rd_rms(rd_rms), .busy(busy), .err(err), .irq(irq)
   );

   always #5 clk_fs = ~clk_fs;

   int cyc = 0;
   always @(posedge clk_fs) cyc <= cyc + 1;

   typedef struct {
      int ch;
      int val;
      int cyc;
      bit last;
      bit chk_irq;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   dly[NCH];
   bit   nev[NCH];
   int   rval[NCH];
   int   model_res[NCH];
   bit   model_err = 0;
   int   n_win = 0;
   int   act_clr = 0, act_en = 0, act_root = 0;
   int   base_clr = 0, base_en = 0, base_root = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: each enabled channel, ascending, costs settle + window + root wait + store.
   function automatic int push_scan(input logic [3:0] mask, input int base, input bit ci);
      int   t;
      bit   ok;
      exp_t e;
      t = base + 1;
      for (int c = 0; c < NCH; c++) begin
         if (mask[c]) begin
            ok = !nev[c] && (dly[c] <= ROOT_TMO - 1);
            t += SETTLE + WIN + (ok ? dly[c] + 1 : ROOT_TMO) + 1;
            e.ch = c;
            e.val = ok ? rval[c] : ONES;
            e.cyc = t;
            e.last = ((mask >> (c + 1)) == 4'd0);
            e.chk_irq = ci;
            model_res[c] = e.val;
            if (!ok) model_err = 1;
            n_win++;
            sb.push_back(e);
         end
      end
      return t;
   endfunction

   task automatic rand_plan();
      for (int c = 0; c < NCH; c++) begin
         dly[c]  = $urandom_range(1, 62);
         nev[c]  = ($urandom_range(0, 5) == 0);
         rval[c] = $urandom_range(0, 'h7FE);
      end
   endtask

   task automatic do_start(input logic [3:0] m, output int c0);
      @(negedge clk_fs);
      ch_en = m; start = 1'b1; irq_clr = 1'b1; c0 = cyc;
      if (m != 4'd0) model_err = 0;
      @(negedge clk_fs);
      start = 1'b0; irq_clr = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk_fs);
   endtask

   task automatic check_end(input string tag, input int last);
      wait_until(last + 3);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      for (int c = 0; c < NCH; c++) begin
         rd_ch = 2'(c);
         #1;
         chk($sformatf("%s_rd_rms%0d", tag, c), rd_rms, model_res[c]);
      end
      chk({tag, "_err"}, err, model_err);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_acc_clr_cnt"}, act_clr - base_clr, n_win);
      chk({tag, "_acc_en_cnt"}, act_en - base_en, n_win * (WIN - 1));
      chk({tag, "_root_cnt"}, act_root - base_root, n_win);
      base_clr = act_clr; base_en = act_en; base_root = act_root; n_win = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_irq"}, irq, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_strobes"}, {rms_vld, acc_clr, acc_en, root_start}, 0);
      chk({tag, "_ch_sel"}, ch_sel, 0);
      chk({tag, "_rms"}, {rms_ch, rms_val}, 0);
      for (int c = 0; c < NCH; c++) begin
         rd_ch = 2'(c);
         #1;
         chk($sformatf("%s_rd_rms%0d", tag, c), rd_rms, 0);
      end
   endtask

   // Behavioural sqrt unit: answers dly[ch] cycles after root_start; a channel
   // marked never answers only after the timeout, when it must be ignored.
   initial begin : responder
      int rch;
      int rdl;
      forever begin
         @(negedge clk_fs);
         if (rst_n && root_start) begin
            rch = int'(ch_sel);
            rdl = nev[rch] ? ROOT_TMO + 2 : dly[rch];
            repeat (rdl) @(negedge clk_fs);
            if (rst_n) begin
               root_done = 1'b1;
               root_q = nev[rch] ? 11'h155 : 11'(rval[rch]);
               @(negedge clk_fs);
               root_done = 1'b0;
            end
         end
      end
   end

   // Monitor: counts strobes and checks every rms_vld against the scoreboard.
   initial begin : monitor
      exp_t e;
      bit   pend_irq;
      pend_irq = 0;
      forever begin
         @(negedge clk_fs);
         if (!rst_n) begin
            pend_irq = 0;
            continue;
         end
         if (pend_irq) begin
            chk("irq_after_scan", irq, 1);
            pend_irq = 0;
         end
         if (acc_clr) begin
            act_clr++;
            if (sb.size() > 0) chk("ch_sel_window", ch_sel, sb[0].ch);
         end
         if (acc_en) act_en++;
         if (root_start) act_root++;
         if (rms_vld) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rms_vld_unexpected: got ch %0d val 0x%0h, expected none (cycle %0d)",
                        rms_ch, rms_val, cyc);
            end else begin
               e = sb.pop_front();
               chk("rms_ch", rms_ch, e.ch);
               chk("rms_val", rms_val, e.val);
               chk("rms_vld_cycle", cyc, e.cyc);
               if (e.last && e.chk_irq) begin
                  chk("irq_before_done", irq, 0);
                  pend_irq = 1;
               end
            end
         end
      end
   end

   initial begin : stimulus
      int c0, last, w;
      logic [3:0] m;
      for (int c = 0; c < NCH; c++) model_res[c] = 0;
      repeat (3) @(negedge clk_fs);
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk_fs);

      // Two channels, fixed root latency and value.
      for (int c = 0; c < NCH; c++) begin
         dly[c] = 10; nev[c] = 0; rval[c] = 'h3A0;
      end
      do_start(4'b0101, c0);
      last = push_scan(4'b0101, c0, 1);
      check_end("two_ch", last);

      // Empty mask: nothing happens.
      do_start(4'b0000, c0);
      repeat (20) @(negedge clk_fs);
      chk("empty_busy", busy, 0);
      chk("empty_irq", irq, 0);
      check_end("empty", cyc);

      // Root timeout on ch1 plus both sides of the timeout boundary.
      rand_plan();
      nev[1] = 1; nev[0] = 0; nev[2] = 0;
      dly[0] = ROOT_TMO - 1; dly[2] = ROOT_TMO;
      m = 4'b0111 | {1'($urandom_range(0, 1)), 3'b000};
      do_start(m, c0);
      last = push_scan(m, c0, 1);
      check_end("timeout", last);

      // Continuous single-channel scans, then stop by clearing the mask.
      rand_plan();
      continuous = 1'b1;
      do_start(4'b1000, c0);
      last = push_scan(4'b1000, c0, 1);
      for (int k = 0; k < 2; k++) begin
         wait_until(last + 20);
         chk("cont_busy", busy, 1);
         irq_clr = 1'b1;
         @(negedge clk_fs);
         irq_clr = 1'b0;
         rand_plan();
         last = push_scan(4'b1000, last, 1);
      end
      ch_en = 4'b0000;
      check_end("continuous", last);
      continuous = 1'b0;

      // irq_clr coincident with the set; start during ACCUM is ignored.
      rand_plan();
      do_start(4'b0110, c0);
      last = push_scan(4'b0110, c0, 0);
      wait_until(c0 + 1 + SETTLE + 100);
      ch_en = 4'b1111; start = 1'b1;
      @(negedge clk_fs);
      start = 1'b0;
      wait_until(last);
      irq_clr = 1'b1;
      @(negedge clk_fs);
      irq_clr = 1'b0;
      chk("irq_clr_priority", irq, 0);
      check_end("clr_prio", last);
      chk("irq_stays_clear", irq, 0);

      // Reset in the middle of ch1's window.
      rand_plan();
      nev[0] = 0; nev[1] = 0;
      do_start(4'b0011, c0);
      last = push_scan(4'b0011, c0, 1);
      w = 0;
      while (sb.size() > 1 && w < 2000) begin
         @(negedge clk_fs);
         w++;
      end
      chk("ch0_done_in_time", sb.size(), 1);
      repeat (60) @(negedge clk_fs);
      chk("in_accum_ch1", {acc_en, ch_sel}, {1'b1, 2'd1});
      rst_n = 1'b0;
      #1;
      sb.delete();
      for (int c = 0; c < NCH; c++) model_res[c] = 0;
      model_err = 0; n_win = 0;
      chk_zero("mid_reset");
      repeat (3) @(negedge clk_fs);
      rst_n = 1'b1;
      base_clr = act_clr; base_en = act_en; base_root = act_root;
      @(negedge clk_fs);
      rand_plan();
      do_start(4'b1011, c0);
      last = push_scan(4'b1011, c0, 1);
      check_end("after_reset", last);

      // Random masks and root behaviour.
      for (int k = 0; k < 3; k++) begin
         rand_plan();
         m = 4'($urandom_range(1, 15));
         do_start(m, c0);
         last = push_scan(m, c0, 1);
         check_end($sformatf("rand%0d", k), last);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
